fft_cache_mm_rd_master: RTL and testbench

Avalon-MM read initiator that fetches one complete FFT frame from the FFT result cache slave over its read-only Avalon port.
- On a start pulse it reads P_NUM_BINS words from the L channel, then P_NUM_BINS words from the R channel, keeping up to P_MAX_PEND reads in flight.
- Returned words are buffered in a small FIFO and presented on a valid/ready stream to the downstream spectrum consumer, tagged with channel and bin index.

---
 rtl/fft_cache_pkg.sv | 22 ++
 rtl/ff_sync_fifo.sv | 55 +++++
 rtl/fft_cache_mm_rd_master.sv | 145 ++++++++++++++
 tb/tb_fft_cache_mm_rd_master.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_cache_pkg.sv
// Shared types and layout helpers for the FFT cache read master.
// Entry layout pushed through the response FIFO is {lchnl, bin, data}.
package fft_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_L,
    S_RD_R,
    S_DRAIN
  } state_t;

  localparam int ADDR_LSB = 2;

  function automatic int chnl_pos(input int aw);
    return aw - 1;
  endfunction

  function automatic int entry_w(input int bw, input int dw);
    return 1 + bw + dw;
  endfunction

endpackage

// File: rtl/ff_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Head entry is always visible on o_data while o_empty is low.
module ff_sync_fifo #(
  parameter int P_W     = 8,
  parameter int P_DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [P_W-1:0]                 i_data,
  input  logic                           i_pop,
  output logic [P_W-1:0]                 o_data,
  output logic [$clog2(P_DEPTH+1)-1:0]   o_count,
  output logic                           o_full,
  output logic                           o_empty
);
  localparam int AW = $clog2(P_DEPTH);
  localparam int CW = $clog2(P_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(P_DEPTH);

  logic [P_W-1:0] r_mem [P_DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fft_cache_mm_rd_master.sv
// Avalon-MM read master fetching one L+R FFT frame from the result cache.
// Responses are tagged in arrival order and streamed out through a FWFT FIFO.
module fft_cache_mm_rd_master
  import fft_cache_pkg::*;
#(
  parameter int P_LB_ADDR_W  = 10,
  parameter int P_LB_DATA_W  = 32,
  parameter int P_BIN_W      = 7,
  parameter int P_NUM_BINS   = 128,
  parameter int P_MAX_PEND   = 4,
  parameter int P_FIFO_DEPTH = 8
) (
  input  logic                   av_clk_ir,
  input  logic                   av_rst_ih,
  input  logic                   start_ih,
  output logic                   busy_oh,
  output logic                   done_oh,
  output logic                   av_read_oh,
  output logic [P_LB_ADDR_W-1:0] av_addr_od,
  input  logic                   av_waitrequest_ih,
  input  logic [P_LB_DATA_W-1:0] av_read_data_id,
  input  logic                   av_read_data_valid_ih,
  output logic [P_LB_DATA_W-1:0] st_data_od,
  output logic                   st_lchnl_oh,
  output logic [P_BIN_W-1:0]     st_bin_od,
  output logic                   st_valid_oh,
  input  logic                   st_ready_ih,
  output logic                   err_oh
);
  localparam int PW   = $clog2(P_MAX_PEND + 1);
  localparam int FW   = $clog2(P_FIFO_DEPTH + 1);
  localparam int EW   = entry_w(P_BIN_W, P_LB_DATA_W);
  localparam int CB   = chnl_pos(P_LB_ADDR_W);
  localparam int LAST = P_NUM_BINS - 1;
  localparam logic [P_BIN_W-1:0] LAST_BIN = LAST[P_BIN_W-1:0];
  localparam logic [P_BIN_W:0]   NB       = P_NUM_BINS[P_BIN_W:0];

  state_t                 r_state;
  state_t                 w_state_nx;
  logic [PW-1:0]          r_pend;
  logic [P_BIN_W-1:0]     r_iss_bin;
  logic [P_BIN_W:0]       r_rsp_cnt;
  logic                   r_err;
  logic                   w_credit;
  logic                   w_rd;
  logic                   w_acc;
  logic                   w_last;
  logic                   w_unsol;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_done;
  logic                   w_lchnl;
  logic [P_BIN_W:0]       w_rsp_off;
  logic [P_BIN_W-1:0]     w_rsp_bin;
  logic [FW-1:0]          w_fifo_cnt;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [EW-1:0]          w_wr_ent;
  logic [EW-1:0]          w_rd_ent;
  logic [P_LB_ADDR_W-1:0] w_addr;

  // Reserve FIFO room for every read in flight so responses never stall.
  assign w_credit = (int'(r_pend) < P_MAX_PEND)
                 && (int'(r_pend) + int'(w_fifo_cnt) < P_FIFO_DEPTH)
                 && !w_fifo_full;
  assign w_rd     = (r_state == S_RD_L || r_state == S_RD_R) && w_credit;
  assign w_acc    = w_rd && !av_waitrequest_ih;
  assign w_last   = w_acc && (r_iss_bin == LAST_BIN);
  assign w_unsol  = av_read_data_valid_ih
                 && (r_pend == '0 || r_state == S_IDLE);
  assign w_push   = av_read_data_valid_ih && !w_unsol;
  assign w_pop    = !w_fifo_empty && st_ready_ih;

  assign w_lchnl   = (r_rsp_cnt < NB);
  assign w_rsp_off = r_rsp_cnt - NB;
  assign w_rsp_bin = w_lchnl ? r_rsp_cnt[P_BIN_W-1:0]
                             : w_rsp_off[P_BIN_W-1:0];
  assign w_wr_ent  = {w_lchnl, w_rsp_bin, av_read_data_id};

  always_comb begin
    w_addr                      = '0;
    w_addr[CB]                  = (r_state == S_RD_L);
    w_addr[ADDR_LSB +: P_BIN_W] = r_iss_bin;
  end

  always_comb begin
    w_state_nx = r_state;
    w_done     = 1'b0;
    unique case (r_state)
      S_IDLE:  if (start_ih) w_state_nx = S_RD_L;
      S_RD_L:  if (w_last)   w_state_nx = S_RD_R;
      S_RD_R:  if (w_last)   w_state_nx = S_DRAIN;
      S_DRAIN: begin
        if (r_pend == '0 && w_fifo_cnt == FW'(1) && w_pop) begin
          w_done     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge av_clk_ir or posedge av_rst_ih) begin
    if (av_rst_ih) begin
      r_state   <= S_IDLE;
      r_pend    <= '0;
      r_iss_bin <= '0;
      r_rsp_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_acc && !w_push)      r_pend <= r_pend + 1'b1;
      else if (!w_acc && w_push) r_pend <= r_pend - 1'b1;
      if (w_last)     r_iss_bin <= '0;
      else if (w_acc) r_iss_bin <= r_iss_bin + 1'b1;
      if (r_state == S_IDLE && start_ih) r_rsp_cnt <= '0;
      else if (w_push)                   r_rsp_cnt <= r_rsp_cnt + 1'b1;
      if (w_unsol) r_err <= 1'b1;
    end
  end

  ff_sync_fifo #(
    .P_W     (EW),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (av_clk_ir),
    .i_rst   (av_rst_ih),
    .i_push  (w_push),
    .i_data  (w_wr_ent),
    .i_pop   (w_pop),
    .o_data  (w_rd_ent),
    .o_count (w_fifo_cnt),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign busy_oh     = (r_state != S_IDLE);
  assign done_oh     = w_done;
  assign av_read_oh  = w_rd;
  assign av_addr_od  = w_addr;
  assign st_valid_oh = !w_fifo_empty;
  assign {st_lchnl_oh, st_bin_od, st_data_od} = w_rd_ent;
  assign err_oh      = r_err;

endmodule

// File: tb/tb_fft_cache_mm_rd_master.sv
// Bench for fft_cache_mm_rd_master: 3-cycle slave model, stream monitor,
// frame-order reference model and per-scenario tasks.
`timescale 1ns/1ps
module tb_fft_cache_mm_rd_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 7;
  localparam int NB = 16;
  localparam int MP = 4;
  localparam int FD = 8;
  localparam int NW = 2 * NB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic waitreq = 1'b0;
  logic st_ready = 1'b0;
  logic inj_v = 1'b0;
  logic busy, done, av_read, st_valid, st_lchnl, err, rdv;
  logic [AW-1:0] av_addr;
  logic [DW-1:0] rdd, st_data;
  logic [BW-1:0] st_bin;
  logic [DW-1:0] salt = '0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fft_cache_mm_rd_master #(
    .P_LB_ADDR_W (AW), .P_LB_DATA_W (DW), .P_BIN_W (BW),
    .P_NUM_BINS (NB), .P_MAX_PEND (MP), .P_FIFO_DEPTH (FD)
  ) dut (
    .av_clk_ir (clk), .av_rst_ih (rst), .start_ih (start),
    .busy_oh (busy), .done_oh (done), .av_read_oh (av_read),
    .av_addr_od (av_addr), .av_waitrequest_ih (waitreq),
    .av_read_data_id (rdd), .av_read_data_valid_ih (rdv),
    .st_data_od (st_data), .st_lchnl_oh (st_lchnl), .st_bin_od (st_bin),
    .st_valid_oh (st_valid), .st_ready_ih (st_ready), .err_oh (err)
  );

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {a, 22'(a) * 22'd2731} ^ salt;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int i);
    return AW'((i < NB ? (1 << (AW - 1)) : 0) + 4 * (i % NB));
  endfunction

  function automatic logic [BW+DW:0] exp_word(input int i);
    logic l = (i < NB);
    return {l, BW'(i % NB), mdata(exp_addr(i))};
  endfunction

  // Slave: fixed 3-cycle read latency, in order, never reset.
  logic [2:0] sp_v = '0;
  logic [AW-1:0] sp_a0 = '0, sp_a1 = '0, sp_a2 = '0;
  always @(posedge clk) begin
    sp_v  <= {sp_v[1:0], av_read && !waitreq};
    sp_a0 <= av_addr;
    sp_a1 <= sp_a0;
    sp_a2 <= sp_a1;
  end
  assign rdv = sp_v[2] | inj_v;
  assign rdd = inj_v ? 32'hDEADBEEF : mdata(sp_a2);

  logic [AW-1:0] acc_q[$];
  int acc_cyc[$];
  logic [BW+DW:0] st_q[$];
  int cyc = 0, done_cnt = 0, start_cyc = 0;
  int viol_pend = 0, viol_occ = 0, viol_hold = 0;
  int acc_n = 0, ret_n = 0, pop_n = 0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic m_acc, m_ret, m_pop;
  assign m_acc = av_read && !waitreq;
  assign m_ret = sp_v[2] && (acc_n > ret_n);
  assign m_pop = st_valid && st_ready;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      acc_n <= 0;
      ret_n <= 0;
      pop_n <= 0;
      prev_stall <= 1'b0;
    end else begin
      acc_n <= acc_n + int'(m_acc);
      ret_n <= ret_n + int'(m_ret);
      pop_n <= pop_n + int'(m_pop);
      if (acc_n + int'(m_acc) - ret_n - int'(m_ret) > MP)
        viol_pend <= viol_pend + 1;
      if (acc_n + int'(m_acc) - pop_n - int'(m_pop) > FD)
        viol_occ <= viol_occ + 1;
      if (prev_stall && (!av_read || av_addr !== prev_addr))
        viol_hold <= viol_hold + 1;
      prev_stall <= av_read && waitreq;
      prev_addr <= av_addr;
      if (m_acc) begin
        acc_q.push_back(av_addr);
        acc_cyc.push_back(cyc);
      end
      if (m_pop) st_q.push_back({st_lchnl, st_bin, st_data});
      if (done) done_cnt <= done_cnt + 1;
      if (start) start_cyc <= cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_cnt != d0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy, done, av_read, st_valid, err} !== 5'b0) begin
      $display("FAIL reset_flags got=%b want=00000",
               {busy, done, av_read, st_valid, err});
    end else passed++;
    checks++;
    if (av_addr !== '0) begin
      $display("FAIL reset_addr got=%h want=000", av_addr);
    end else passed++;
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || av_read !== 1'b0) begin
      $display("FAIL idle_after_reset busy=%b rd=%b want 0 0", busy, av_read);
    end else passed++;
  endtask

  task automatic test_basic();
    int ab, sb, d0;
    bit ok, seq;
    salt = $urandom;
    st_ready = 1'b1;
    ab = acc_q.size(); sb = st_q.size(); d0 = done_cnt;
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL basic_busy_rise got=%b want=1", busy);
    end else passed++;
    wait_done(400, ok);
    checks++;
    if (!ok) $display("FAIL basic_timeout got=no_done want=done");
    else passed++;
    repeat (3) tick();
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0 || err !== 1'b0) begin
      $display("FAIL basic_end dones=%0d busy=%b err=%b want 1 0 0",
               done_cnt - d0, busy, err);
    end else passed++;
    checks++;
    if (acc_q.size() <= ab || acc_cyc[ab] != start_cyc + 1) begin
      $display("FAIL basic_first_issue got_cyc=%0d want=%0d",
               acc_q.size() > ab ? acc_cyc[ab] : -1, start_cyc + 1);
    end else passed++;
    seq = (acc_q.size() - ab == NW);
    for (int i = 1; i < NW && seq; i++)
      if (acc_cyc[ab + i] != acc_cyc[ab] + i) seq = 1'b0;
    checks++;
    if (!seq) $display("FAIL basic_back_to_back got=gaps want=consecutive");
    else passed++;
    checks++;
    if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
      $display("FAIL basic_count reads=%0d words=%0d want=%0d",
               acc_q.size() - ab, st_q.size() - sb, NW);
    end else passed++;
    for (int i = 0; i < NW && ab + i < acc_q.size() &&
         sb + i < st_q.size(); i++) begin
      checks++;
      if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
        $display("FAIL basic_item%0d addr=%h word=%h want addr=%h word=%h",
                 i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
      end else passed++;
    end
  endtask

  task automatic test_waitreq();
    int ab, sb;
    bit ok;
    salt = $urandom;
    st_ready = 1'b1;
    ab = acc_q.size(); sb = st_q.size();
    pulse_start();
    tick();
    waitreq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (av_read !== 1'b1 || av_addr !== 10'h204) begin
        $display("FAIL wait_hold%0d rd=%b addr=%h want 1 204", k, av_read, av_addr);
      end else passed++;
      tick();
    end
    waitreq = 1'b0;
    wait_done(400, ok);
    checks++;
    if (!ok) $display("FAIL wait_timeout got=no_done want=done");
    else passed++;
    checks++;
    if (viol_hold != 0) $display("FAIL wait_stable got=%0d want=0", viol_hold);
    else passed++;
    checks++;
    if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
      $display("FAIL wait_count reads=%0d words=%0d want=%0d",
               acc_q.size() - ab, st_q.size() - sb, NW);
    end else passed++;
    for (int i = 0; i < NW && ab + i < acc_q.size() &&
         sb + i < st_q.size(); i++) begin
      checks++;
      if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
        $display("FAIL wait_item%0d addr=%h word=%h want addr=%h word=%h",
                 i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
      end else passed++;
    end
  endtask

  task automatic test_backpressure();
    int ab, sb;
    bit ok;
    salt = $urandom;
    st_ready = 1'b0;
    ab = acc_q.size(); sb = st_q.size();
    pulse_start();
    repeat (40) tick();
    checks++;
    if (acc_q.size() - ab != FD || av_read !== 1'b0) begin
      $display("FAIL bp_credit reads=%0d rd=%b want %0d 0",
               acc_q.size() - ab, av_read, FD);
    end else passed++;
    checks++;
    if (st_valid !== 1'b1) $display("FAIL bp_valid got=%b want=1", st_valid);
    else passed++;
    st_ready = 1'b1;
    wait_done(800, ok);
    checks++;
    if (!ok) $display("FAIL bp_timeout got=no_done want=done");
    else passed++;
    checks++;
    if (viol_occ != 0 || viol_pend != 0) begin
      $display("FAIL bp_overflow occ=%0d pend=%0d want 0 0", viol_occ, viol_pend);
    end else passed++;
    checks++;
    if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
      $display("FAIL bp_count reads=%0d words=%0d want=%0d",
               acc_q.size() - ab, st_q.size() - sb, NW);
    end else passed++;
    for (int i = 0; i < NW && ab + i < acc_q.size() &&
         sb + i < st_q.size(); i++) begin
      checks++;
      if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
        $display("FAIL bp_item%0d addr=%h word=%h want addr=%h word=%h",
                 i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
      end else passed++;
    end
  endtask

  task automatic test_restart_ignored();
    int ab, sb, d0;
    bit ok;
    salt = $urandom;
    st_ready = 1'b1;
    ab = acc_q.size(); sb = st_q.size(); d0 = done_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (acc_q.size() - ab > NB) ok = 1'b1;
    end
    checks++;
    if (!ok) $display("FAIL restart_reach_r got=no_r_read want=r_read");
    else passed++;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, ok);
    repeat (10) tick();
    checks++;
    if (!ok || done_cnt - d0 != 1 || busy !== 1'b0) begin
      $display("FAIL restart_done dones=%0d busy=%b want 1 0", done_cnt - d0, busy);
    end else passed++;
    checks++;
    if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
      $display("FAIL restart_count reads=%0d words=%0d want=%0d",
               acc_q.size() - ab, st_q.size() - sb, NW);
    end else passed++;
    for (int i = 0; i < NW && ab + i < acc_q.size() &&
         sb + i < st_q.size(); i++) begin
      checks++;
      if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
        $display("FAIL restart_item%0d addr=%h word=%h want addr=%h word=%h",
                 i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
      end else passed++;
    end
  endtask

  task automatic test_random();
    int ab, sb, d0;
    bit ok;
    for (int f = 0; f < 3; f++) begin
      salt = $urandom;
      ab = acc_q.size(); sb = st_q.size(); d0 = done_cnt;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
        waitreq = ($urandom_range(0, 9) < 3);
        st_ready = ($urandom_range(0, 9) < 6);
        tick();
        if (done_cnt != d0) ok = 1'b1;
      end
      waitreq = 1'b0;
      st_ready = 1'b1;
      checks++;
      if (!ok) $display("FAIL rand%0d_timeout got=no_done want=done", f);
      else passed++;
      checks++;
      if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
        $display("FAIL rand%0d_count reads=%0d words=%0d want=%0d",
                 f, acc_q.size() - ab, st_q.size() - sb, NW);
      end else passed++;
      for (int i = 0; i < NW && ab + i < acc_q.size() &&
           sb + i < st_q.size(); i++) begin
        checks++;
        if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
          $display("FAIL rand%0d_item%0d addr=%h word=%h want addr=%h word=%h",
                   f, i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
        end else passed++;
      end
      repeat (4) tick();
    end
    checks++;
    if (viol_hold != 0 || viol_pend != 0 || viol_occ != 0) begin
      $display("FAIL rand_rules hold=%0d pend=%0d occ=%0d want 0 0 0",
               viol_hold, viol_pend, viol_occ);
    end else passed++;
  endtask

  task automatic test_unsolicited();
    int sb;
    st_ready = 1'b1;
    repeat (3) tick();
    sb = st_q.size();
    checks++;
    if (err !== 1'b0) $display("FAIL unsol_pre_err got=%b want=0", err);
    else passed++;
    inj_v = 1'b1;
    tick();
    inj_v = 1'b0;
    repeat (5) tick();
    checks++;
    if (st_q.size() != sb || st_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL unsol_drop words=%0d valid=%b busy=%b want 0 0 0",
               st_q.size() - sb, st_valid, busy);
    end else passed++;
    checks++;
    if (err !== 1'b1) $display("FAIL unsol_err got=%b want=1", err);
    else passed++;
    repeat (10) tick();
    checks++;
    if (err !== 1'b1) $display("FAIL unsol_sticky got=%b want=1", err);
    else passed++;
  endtask

  task automatic test_reset_inflight();
    int ab, sb;
    bit ok;
    salt = $urandom;
    st_ready = 1'b1;
    ab = acc_q.size();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (acc_q.size() - ab >= 3) ok = 1'b1;
      else tick();
    end
    checks++;
    if (!ok) $display("FAIL rstf_inflight got=<3 want=3");
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, av_read, st_valid, err} !== 5'b0 || av_addr !== '0) begin
      $display("FAIL rstf_outputs flags=%b addr=%h want 00000 000",
               {busy, done, av_read, st_valid, err}, av_addr);
    end else passed++;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    checks++;
    if (err !== 1'b1 || st_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL rstf_late err=%b valid=%b busy=%b want 1 0 0",
               err, st_valid, busy);
    end else passed++;
    salt = $urandom;
    ab = acc_q.size(); sb = st_q.size();
    pulse_start();
    wait_done(400, ok);
    checks++;
    if (!ok || err !== 1'b1) begin
      $display("FAIL rstf_refetch done=%b err=%b want 1 1", ok, err);
    end else passed++;
    checks++;
    if (acc_q.size() - ab != NW || st_q.size() - sb != NW) begin
      $display("FAIL rstf_count reads=%0d words=%0d want=%0d",
               acc_q.size() - ab, st_q.size() - sb, NW);
    end else passed++;
    for (int i = 0; i < NW && ab + i < acc_q.size() &&
         sb + i < st_q.size(); i++) begin
      checks++;
      if (acc_q[ab + i] !== exp_addr(i) || st_q[sb + i] !== exp_word(i)) begin
        $display("FAIL rstf_item%0d addr=%h word=%h want addr=%h word=%h",
                 i, acc_q[ab + i], st_q[sb + i], exp_addr(i), exp_word(i));
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_waitreq();
    test_backpressure();
    test_restart_ignored();
    test_random();
    test_unsolicited();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
